// File: rtl/serial_port_pkg.sv
// Shared definitions for the bus serial port: register offsets, STATUS bit
// positions and the state encoding used by both the TX and RX engines.
package serial_port_pkg;

  localparam logic [15:0] STATUS_OFS = 16'd0;
  localparam logic [15:0] DATA_OFS   = 16'd1;

  localparam int ST_RX_READY    = 0;
  localparam int ST_TX_NOT_FULL = 1;
  localparam int ST_OVERRUN     = 2;
  localparam int ST_FRAMING_ERR = 3;
  localparam int ST_LOOPBACK    = 6;
  localparam int ST_TX_BUSY     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } serial_state_e;

endpackage

// File: rtl/bus_serial_port_if.sv
// CPU6 system bus as seen by one memory-mapped responder.
interface bus_serial_port_if;
  logic [15:0] address;
  logic        write_en;
  logic [7:0]  data_c2r;
  logic [7:0]  data_r2c;

  modport master (output address, output write_en, output data_c2r, input data_r2c);
  modport slave  (input address, input write_en, input data_c2r, output data_r2c);
endinterface

// File: rtl/serial_rx_deser.sv
// 8N1 receiver: 2-flop synchroniser plus sampling FSM. Emits one-cycle pulses
// for a good byte (byte_valid/rx_byte) or a bad stop bit (framing_err_pulse).
module serial_rx_deser
  import serial_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = 174
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd_in,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       framing_err_pulse
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;

  serial_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          byte_valid_q, framing_err_q;

  always_comb begin
    sync1_d = rxd_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // A framing error drops straight to IDLE; the falling-edge detector then
  // naturally waits for the line to go high before the next frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      byte_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (prev_q && !sync2_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= sync2_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_q     <= '0;
            shift_q   <= {sync2_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (sync2_q) byte_valid_q  <= 1'b1;
            else         framing_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_valid        = byte_valid_q;
  assign rx_byte           = shift_q;
  assign framing_err_pulse = framing_err_q;

endmodule

// File: rtl/bus_serial_port.sv
// Memory-mapped 8N1 serial console (STATUS at BASE_ADDR, DATA at BASE_ADDR+1)
// with a TX FIFO and one-byte RX holding register. SERIAL_LOOPBACK_EN adds STATUS bit6 loopback.
module bus_serial_port
  import serial_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter int          CLKS_PER_BIT = 174,
  parameter int          TX_DEPTH     = 4
) (
  input  logic               clock,
  input  logic               reset,
  bus_serial_port_if.slave   bus,
  input  logic               rxd,
  output logic               txd
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TX_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   STATUS_ADDR = BASE_ADDR + STATUS_OFS;
  localparam logic [15:0]   DATA_ADDR   = BASE_ADDR + DATA_OFS;

  logic sel_status, sel_data, rd_data, wr_data, wr_status, rx_pop;
  logic tx_push, tx_pop, fifo_full, fifo_empty, tx_busy;
  logic rx_in, byte_valid, framing_err_pulse;
  logic [7:0] rx_byte, status, fifo_head;

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [7:0] rdata_q, rdata_d, rx_hold_q, rx_hold_d;
  logic rd_data_prev_q, rd_data_prev_d;
  logic rx_ready_q, rx_ready_d, overrun_q, overrun_d, framing_q, framing_d;

  serial_state_e tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_line_q;

`ifdef SERIAL_LOOPBACK_EN
  logic loopback_q, loopback_d;
`endif

  always_comb begin
    sel_status = (bus.address == STATUS_ADDR);
    sel_data   = (bus.address == DATA_ADDR);
    rd_data    = sel_data & ~bus.write_en;
    wr_data    = sel_data & bus.write_en;
    wr_status  = sel_status & bus.write_en;
    rx_pop     = rd_data & ~rd_data_prev_q;
    fifo_full  = (count_q == (AW+1)'(TX_DEPTH));
    fifo_empty = (count_q == '0);
    fifo_head  = fifo_mem[rd_ptr_q];
    tx_busy    = ~fifo_empty | (tx_state_q != IDLE);
    tx_pop     = ~fifo_empty &
                 ((tx_state_q == IDLE) || (tx_state_q == STOP && tx_cnt_q == TX_LAST));
    tx_push    = wr_data & (~fifo_full | tx_pop);
  end

  always_comb begin
    status                 = 8'h00;
    status[ST_RX_READY]    = rx_ready_q;
    status[ST_TX_NOT_FULL] = ~fifo_full;
    status[ST_OVERRUN]     = overrun_q;
    status[ST_FRAMING_ERR] = framing_q;
    status[ST_TX_BUSY]     = tx_busy;
`ifdef SERIAL_LOOPBACK_EN
    status[ST_LOOPBACK]    = loopback_q;
`endif
  end

  // Byte delivery beats a same-cycle DATA-read pop, and a new error beats a
  // same-cycle STATUS-write clear.
  always_comb begin
    rd_data_prev_d = rd_data;
    rdata_d        = 8'h00;
    if (!bus.write_en && sel_status) rdata_d = status;
    else if (rd_data)                rdata_d = rx_hold_q;
    rx_hold_d  = byte_valid ? rx_byte : rx_hold_q;
    rx_ready_d = byte_valid | (rx_ready_q & ~rx_pop);
    overrun_d  = (overrun_q & ~wr_status) | (byte_valid & rx_ready_q & ~rx_pop);
    framing_d  = (framing_q & ~wr_status) | framing_err_pulse;
    wr_ptr_d   = wr_ptr_q + AW'(tx_push);
    rd_ptr_d   = rd_ptr_q + AW'(tx_pop);
    count_d    = count_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
`ifdef SERIAL_LOOPBACK_EN
    loopback_d = wr_status ? bus.data_c2r[ST_LOOPBACK] : loopback_q;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q        <= 8'h00;
      rx_hold_q      <= 8'h00;
      rd_data_prev_q <= 1'b0;
      rx_ready_q     <= 1'b0;
      overrun_q      <= 1'b0;
      framing_q      <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
`ifdef SERIAL_LOOPBACK_EN
      loopback_q     <= 1'b0;
`endif
    end else begin
      rdata_q        <= rdata_d;
      rx_hold_q      <= rx_hold_d;
      rd_data_prev_q <= rd_data_prev_d;
      rx_ready_q     <= rx_ready_d;
      overrun_q      <= overrun_d;
      framing_q      <= framing_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
`ifdef SERIAL_LOOPBACK_EN
      loopback_q     <= loopback_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push) fifo_mem[wr_ptr_q] <= bus.data_c2r;
  end

  // STOP pops the next byte on its last clock so frames run back to back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        IDLE: begin
          if (tx_pop) begin
            tx_state_q <= START;
            tx_shift_q <= fifo_head;
            tx_line_q  <= 1'b0;
            tx_cnt_q   <= '0;
          end
        end
        START: begin
          if (tx_cnt_q == TX_LAST) begin
            tx_state_q <= DATA;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt_q == TX_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= STOP;
              tx_line_q  <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_line_q  <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt_q == TX_LAST) begin
            tx_cnt_q <= '0;
            if (tx_pop) begin
              tx_state_q <= START;
              tx_shift_q <= fifo_head;
              tx_line_q  <= 1'b0;
            end else begin
              tx_state_q <= IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_LOOPBACK_EN
  assign rx_in = loopback_q ? tx_line_q : rxd;
  assign txd   = loopback_q ? 1'b1 : tx_line_q;
`else
  assign rx_in = rxd;
  assign txd   = tx_line_q;
`endif

  assign bus.data_r2c = rdata_q;

  serial_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock             (clock),
    .reset             (reset),
    .rxd_in            (rx_in),
    .byte_valid        (byte_valid),
    .rx_byte           (rx_byte),
    .framing_err_pulse (framing_err_pulse)
  );

endmodule

// File: tb/tb_bus_serial_port.sv
// Self-checking bench for bus_serial_port (CLKS_PER_BIT=4, TX_DEPTH=4); the
// loopback sequence is compiled in only with SERIAL_LOOPBACK_EN.
module tb_bus_serial_port;

  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset;
  logic rxd;
  logic txd;

  bus_serial_port_if bus_if();

  bus_serial_port #(.BASE_ADDR(16'hF200), .CLKS_PER_BIT(CPB), .TX_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave),
    .rxd   (rxd),
    .txd   (txd)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] rd_q[$];
  logic       txd_q[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 8'h%02h, want 8'h%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Every clock also checks txd against the expected-level queue, if any.
  task automatic tick();
    logic e;
    @(posedge clock);
    #1;
    if (txd_q.size() > 0) begin
      e = txd_q.pop_front();
      check8("txd", {7'd0, txd}, {7'd0, e});
    end
  endtask

  task automatic idleBus();
    bus_if.address  = 16'h0000;
    bus_if.write_en = 1'b0;
    bus_if.data_c2r = 8'h00;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic we, input logic [7:0] d,
                               input logic chk, input logic [7:0] exp);
    bus_if.address  = a;
    bus_if.write_en = we;
    bus_if.data_c2r = d;
    if (chk) rd_q.push_back(exp);
  endtask

  task automatic checkOutput(input string name);
    if (rd_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s: scoreboard empty, got 8'h%02h", name, bus_if.data_r2c);
    end else begin
      check8(name, bus_if.data_r2c, rd_q.pop_front());
    end
  endtask

  task automatic busCycle(input logic [15:0] a, input logic we, input logic [7:0] d,
                          input logic chk, input logic [7:0] exp, input string name);
    applyStimulus(a, we, d, chk, exp);
    tick();
    idleBus();
    if (chk) checkOutput(name);
  endtask

  task automatic pushFrame(input logic [7:0] b, input bit skip_first);
    logic lv[$];
    for (int i = 0; i < CPB; i++) lv.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) lv.push_back(b[k]);
    for (int i = 0; i < CPB; i++) lv.push_back(1'b1);
    if (skip_first) void'(lv.pop_front());
    foreach (lv[i]) txd_q.push_back(lv[i]);
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) txd_q.push_back(1'b1);
  endtask

  task automatic waitTxLow(input int budget, input string name);
    int n;
    n = 0;
    while (txd !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check8(name, {7'd0, txd}, 8'h00);
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (CPB) tick();
    end
    rxd = stop_bit;
    repeat (CPB) tick();
    rxd = 1'b1;
    repeat (3 * CPB) tick();
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{16'hF200, 1'b0, 8'h00, 1'b1, 8'h02};
    vecs[1] = '{16'hF202, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[2] = '{16'hF1FF, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[3] = '{16'hF300, 1'b1, 8'hAA, 1'b0, 8'h00};
    vecs[4] = '{16'hF200, 1'b0, 8'h00, 1'b1, 8'h02};
    vecs[5] = '{16'hF200, 1'b1, 8'hBF, 1'b0, 8'h00};
    vecs[6] = '{16'hF200, 1'b0, 8'h00, 1'b1, 8'h02};
    vecs[7] = '{16'hF202, 1'b1, 8'h55, 1'b0, 8'h00};
    vecs[8] = '{16'hF200, 1'b0, 8'h00, 1'b1, 8'h02};

    reset = 1'b1;
    rxd   = 1'b1;
    idleBus();
    repeat (3) tick();
    check8("reset_txd", {7'd0, txd}, 8'h01);
    check8("reset_rdata", bus_if.data_r2c, 8'h00);
    reset = 1'b0;
    tick();

    // Register map, ignored addresses and bit-6 write with loopback absent.
    for (int i = 0; i < 9; i++) begin
      busCycle(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].chk, vecs[i].exp,
               $sformatf("vec%0d", i));
    end
    check8("idle_txd", {7'd0, txd}, 8'h01);

    // Single 8'h55 frame with busy visible mid-frame.
    busCycle(16'hF201, 1'b1, 8'h55, 1'b0, 8'h00, "wr55");
    waitTxLow(10, "tx55_start");
    pushFrame(8'h55, 1'b1);
    bus_if.address = 16'hF200;
    for (int i = 0; i < 39; i++) begin
      tick();
      if (i == 20) check8("busy_mid", bus_if.data_r2c & 8'h80, 8'h80);
    end
    idleBus();
    pushIdle(4);
    repeat (4) tick();
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h02, "status_after55");

    // While 8'hC3 is on the line, six writes: only four fit in the FIFO.
    busCycle(16'hF201, 1'b1, 8'hC3, 1'b0, 8'h00, "wrC3");
    waitTxLow(10, "txC3_start");
    pushFrame(8'hC3, 1'b1);
    for (int k = 1; k <= 4; k++) pushFrame(8'(k), 1'b0);
    pushIdle(20);
    for (int k = 1; k <= 6; k++) busCycle(16'hF201, 1'b1, 8'(k), 1'b0, 8'h00, "wr_burst");
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h80, "status_full");
    while (txd_q.size() > 0) tick();
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h02, "status_drained");

    // Receive 8'hA3; holding DATA for three cycles pops once.
    sendRx(8'hA3, 1'b1);
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h03, "status_rx");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'hF201, 1'b0, 8'h00, 1'b1, 8'hA3);
      tick();
      checkOutput("data_hold");
    end
    idleBus();
    tick();
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h02, "status_popped");

    // Overrun, framing error, glitch rejection, then clear via STATUS write.
    sendRx(8'h11, 1'b1);
    sendRx(8'h22, 1'b1);
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h07, "status_overrun");
    busCycle(16'hF201, 1'b0, 8'h00, 1'b1, 8'h22, "data_overrun");
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h06, "status_after_read");
    sendRx(8'h5A, 1'b0);
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h0E, "status_framing");
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (3 * CPB) tick();
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h0E, "status_glitch");
    busCycle(16'hF200, 1'b1, 8'h00, 1'b0, 8'h00, "clear_flags");
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h02, "status_cleared");

    // Reset mid-frame: line goes high at once and the queued byte is lost.
    busCycle(16'hF201, 1'b1, 8'h3C, 1'b0, 8'h00, "wr3C");
    busCycle(16'hF201, 1'b1, 8'h3D, 1'b0, 8'h00, "wr3D");
    waitTxLow(10, "tx3C_start");
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check8("midreset_txd", {7'd0, txd}, 8'h01);
    check8("midreset_rdata", bus_if.data_r2c, 8'h00);
    repeat (2) tick();
    reset = 1'b0;
    pushIdle(60);
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h02, "status_after_reset");
    while (txd_q.size() > 0) tick();

`ifdef SERIAL_LOOPBACK_EN
    busCycle(16'hF200, 1'b1, 8'h40, 1'b0, 8'h00, "lb_enable");
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h42, "lb_status");
    pushIdle(70);
    busCycle(16'hF201, 1'b1, 8'h7E, 1'b0, 8'h00, "lb_wr7E");
    while (txd_q.size() > 0) tick();
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h43, "lb_status_rx");
    busCycle(16'hF201, 1'b0, 8'h00, 1'b1, 8'h7E, "lb_data");
    busCycle(16'hF200, 1'b1, 8'h00, 1'b0, 8'h00, "lb_disable");
    busCycle(16'hF200, 1'b0, 8'h00, 1'b1, 8'h02, "lb_status_off");
`endif

    if (rd_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries left, want 0", rd_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_serial_port.md
Name: bus_serial_port

Overview:
- Memory-mapped serial console responder on the CPU6 system bus: the CPU is the bus initiator, and this block answers it alongside the RAM and LED panel.
- Provides an 8N1 UART transmitter fed by a small TX FIFO, and a receiver with a one-byte holding register.
- Exposes two bus registers, STATUS and DATA, at BASE_ADDR and BASE_ADDR+1.
- Instantiated in the board top level on the shared bus clock.

Parameters:
- BASE_ADDR, 16'hF200, address of STATUS; DATA is at BASE_ADDR+1.
- CLKS_PER_BIT, 174, bus clocks per serial bit (20 MHz / 115200); legal range is at least 4.
- TX_DEPTH, 4, TX FIFO entries; must be a power of two and at least 2.

Ports:
- clock, in, 1, bus clock.
- reset, in, 1, asynchronous, active-high.
- address, in, 16, CPU address bus.
- write_en, in, 1, CPU write strobe; 1 = write this cycle.
- data_c2r, in, 8, CPU write data.
- data_r2c, out, 8, read data; 8'h00 when not selected, so the top level can OR it with other responders.
- rxd, in, 1, serial input; idles high; asynchronous to clock.
- txd, out, 1, serial output; idles high.

Behaviour:
Reset:
- txd=1, data_r2c=0.
- FIFO empty, rx_ready=0, overrun=0, framing_err=0.
- Both state machines in IDLE.
Bus reads:
- Registered, 1-cycle latency: data_r2c at cycle N+1 reflects the address at cycle N, with write_en=0.
STATUS bit map:
- bit0 rx_ready
- bit1 tx_not_full
- bit2 overrun
- bit3 framing_err
- bit7 tx_busy (FIFO non-empty or shifter active)
- all other bits 0
DATA reads:
- Returns the RX holding register.
- Clears rx_ready only on the first cycle of a DATA read. A new read is one where the previous cycle was not a DATA read, so a CPU holding the address for several cycles pops once.
Writes:
- Write to DATA pushes data_c2r into the TX FIFO.
- If the FIFO is full, the write is dropped silently, unless the TX engine pops in the same cycle; then the push is accepted.
- Any write to STATUS clears overrun and framing_err. Bit 6 is handled under Optional Feature.
- Writes outside the two addresses are ignored.
TX FSM (IDLE -> START -> DATA -> STOP -> IDLE):
- IDLE: pop when FIFO is non-empty; next clock enter START.
- START: txd=0 for CLKS_PER_BIT clocks.
- DATA: 8 bits, LSB first, CLKS_PER_BIT each.
- STOP: txd=1 for CLKS_PER_BIT; then pop the next byte if present, giving back-to-back frames with no idle gap.
- FIFO pointers wrap modulo TX_DEPTH; count is TX_DEPTH+1 states wide.
RX FSM (IDLE -> START -> DATA -> STOP):
- rxd passes through a 2-flop synchroniser.
- IDLE: wait for the synchronised rxd falling edge.
- START: sample at CLKS_PER_BIT/2 (integer divide). If high, it is a glitch: return to IDLE with no flags.
- DATA: sample each subsequent bit CLKS_PER_BIT later.
- STOP: if the stop sample is 0, set framing_err, discard the byte, and return to IDLE once rxd is high.
- If the stop sample is 1, load the holding register and set rx_ready. If rx_ready was already 1, the new byte overwrites it and overrun is set.
Simultaneous events:
- Byte delivery and a DATA-read pop in the same cycle: delivery wins, rx_ready stays 1, overrun stays clear.
- STATUS-write clear and a new error in the same cycle: the flag ends set.
Reset mid-frame:
- Aborts both FSMs immediately.
- txd returns high asynchronously and FIFO contents are lost.

Optional Feature:
- Macro SERIAL_LOOPBACK_EN.
- Defined: STATUS bit6 is a R/W loopback enable, reset value 0. When set, the RX synchroniser input is the internal TX line, and txd is held at 1.
- Undefined: bit6 is ignored on writes, reads 0, and there is no loopback mux.

Decomposition:
- Package serial_port_pkg holds:
  - register offsets: STATUS_OFS=0, DATA_OFS=1
  - STATUS bit indices
  - shared TX/RX state encoding: IDLE, START, DATA, STOP
- One natural sub-module, serial_rx_deser: synchroniser plus RX FSM. It outputs a 1-cycle byte_valid, byte, and framing_err_pulse.
- FIFO, TX FSM and bus decode stay in bus_serial_port.

Test Plan (CLKS_PER_BIT=4, TX_DEPTH=4):
- Reset, then read 16'hF200 -> data_r2c=8'h02 one cycle later; txd=1.
- Write 8'h55 to 16'hF201 -> txd frame is 0,1,0,1,0,1,0,1,0,1, each level 4 clocks; STATUS bit7 is 1 during the frame and 0 after.
- Write 6 bytes 8'h01..8'h06 back-to-back -> only 8'h01..8'h04 are transmitted; frames are contiguous; tx_not_full=0 after the 4th write.
- Drive rxd with frame 8'hA3 -> rx_ready=1. Read F201 for 3 cycles -> returns 8'hA3 and pops exactly once; STATUS then reads 8'h02.
- Send 8'h11 then 8'h22 without reading -> DATA=8'h22 and overrun=1. Send a frame with stop bit 0 -> framing_err=1. Write F200 -> both flags clear.
- With SERIAL_LOOPBACK_EN, write 8'h40 to F200, then 8'h7E to F201 -> rx_ready=1 and DATA=8'h7E; txd stays 1 throughout. Also assert reset mid-frame -> txd=1 and STATUS=8'h02 after release.
